fp_dot_accumulator: RTL and testbench
=====================================

FP_DOT_ACCUMULATOR -- requirements
Module: fp_dot_accumulator

Interface
REQ-001 SHALL have parameter K, default 4, meaning products summed per dot product; legal range 1..256.
REQ-002 SHALL have parameter CNT_W, default $clog2(K)+1, meaning term-counter width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port i_clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_prod  input  32  IEEE-754 single product from upstream multiplier.
REQ-007 SHALL have port i_prod_vld  input  1  i_prod valid this cycle; no backpressure, every valid accepted.
REQ-008 SHALL have port i_prod_ovf  input  1  upstream overflow/NaN flag paired with i_prod.
REQ-009 SHALL have port i_clr  input  1  synchronous abort of the partial dot product.
REQ-010 SHALL have port o_sum  output  32  completed dot-product sum, registered.
REQ-011 SHALL have port o_sum_vld  output  1  one-cycle pulse, o_sum valid.
REQ-012 SHALL have port o_overflow  output  1  sticky overflow/NaN flag for the dot product in o_sum.

Function
REQ-013 SHALL use two states: IDLE (term count 0) and ACCUM (1..K-1 terms held).
REQ-014 SHALL, in IDLE with i_prod_vld, load the accumulator with i_prod (no add to zero), load the sticky flag with i_prod_ovf, set count=1, and go to ACCUM; with K=1, complete instead (REQ-016).
REQ-015 SHALL, in ACCUM with i_prod_vld, set acc <= acc + i_prod, sticky |= i_prod_ovf | adder_ovf, count++.
REQ-016 SHALL, on the K-th valid term, register o_sum = final sum and o_overflow = final sticky value, pulse o_sum_vld the next cycle, and return to IDLE.
REQ-017 SHALL accept the first term of the next dot product in the cycle immediately after the K-th term, sustaining one term per cycle.
REQ-018 SHALL hold state, counter and accumulator unchanged when i_prod_vld=0; gaps between terms are legal.
REQ-019 SHALL hold o_sum and o_overflow until the next completion; o_sum_vld SHALL be 0 except for the completion pulse.
REQ-020 SHALL, on i_clr, discard the partial sum and flag and go to IDLE; if i_prod_vld is also high, that term SHALL become term 1 of a new dot product.
REQ-021 SHALL perform adds combinationally in one cycle: align to the larger exponent, add/subtract 24-bit significands, renormalise, and round toward zero (truncate).
REQ-022 SHALL flush subnormal inputs and subnormal results to +/-0.
REQ-023 SHALL output 7FC00000 when either operand is NaN or for inf + (-inf), and set adder_ovf.
REQ-024 SHALL output +/-inf for inf + finite, and for exponent overflow, with adder_ovf set.
REQ-025 SHALL return the larger operand unchanged when the alignment shift is 25 or more.
REQ-026 SHALL produce +0 (00000000) on exact cancellation; -0 + -0 SHALL give -0.

Reset
REQ-027 SHALL, on i_rst, set o_sum=0, o_sum_vld=0, o_overflow=0, count=0, acc=0 and state=IDLE.
REQ-028 SHALL give i_rst priority over i_clr and i_prod_vld; a partial dot product in progress SHALL be discarded with no o_sum_vld.

Structure
REQ-029 SHALL take from shared package fp32_pkg: FP_NAN=7FC00000, FP_INF exponent FF, EXP_BIAS=127, and sign/exponent/mantissa field widths; the upstream multiplier uses the same constants.
REQ-030 SHALL put the combinational adder in one sub-module, fp_adder_32bit (ports a, b, sum, ovf); counter, FSM and sticky flag SHALL live in fp_dot_accumulator.

Verification
REQ-031 SHALL cover: K=4, back-to-back terms 3F800000, 40000000, 40400000, 40800000 -> one cycle later o_sum=41200000, o_sum_vld high for exactly one cycle, o_overflow=0.
REQ-032 SHALL cover: terms 3F800000, BF800000, 3F000000, BF000000 -> o_sum=00000000, o_overflow=0.
REQ-033 SHALL cover: terms 7F7FFFFF, 7F7FFFFF, 00000000, 00000000 -> o_sum=7F800000, o_overflow=1.
REQ-034 SHALL cover: terms 7F800000, FF800000, 3F800000, 3F800000 -> o_sum=7FC00000, o_overflow=1.
REQ-035 SHALL cover: two 3F800000 terms, then i_clr with i_prod_vld=1 and 3F800000, then three more 3F800000 -> single o_sum_vld pulse, o_sum=40800000.
REQ-036 SHALL cover: 3F800000 terms with 3-cycle gaps, i_rst after term 2, then four 3F800000 terms -> no pulse before reset, then o_sum=40800000.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and types, common to the upstream
// multiplier and the dot-product accumulator.
package fp32_pkg;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] FP_EXP_INF = 8'hFF;
    localparam logic [31:0]      FP_NAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [MAN_W-1:0]  man;
    } fp32_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;
endpackage

// File: rtl/fp_adder_32bit.sv
// Single-cycle combinational fp32 adder: round toward zero, subnormals flushed,
// NaN/inf/overflow reported on ovf.
module fp_adder_32bit
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);
    fp32_t              fa, fb, big, sml;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EXP_W-1:0]   diff;
    logic [49:0]        sig_b, sig_s, r;
    logic [5:0]         lead;
    logic [23:0]        nrm;
    logic signed [9:0]  exp_r;

    always_comb begin
        fa     = fp32_t'(a);
        fb     = fp32_t'(b);
        a_nan  = (fa.exp == FP_EXP_INF) && (fa.man != '0);
        b_nan  = (fb.exp == FP_EXP_INF) && (fb.man != '0);
        a_inf  = (fa.exp == FP_EXP_INF) && (fa.man == '0);
        b_inf  = (fb.exp == FP_EXP_INF) && (fb.man == '0);
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);

        if ({fa.exp, fa.man} >= {fb.exp, fb.man}) begin
            big = fa;
            sml = fb;
        end else begin
            big = fb;
            sml = fa;
        end
        diff = big.exp - sml.exp;

        // 25 guard bits below the significand keep the aligned operand exact
        // (shift < 25), so truncating after the add is a true round-to-zero.
        sig_b = {1'b0, 1'b1, big.man, 25'b0};
        sig_s = {1'b0, 1'b1, sml.man, 25'b0} >> diff;
        r     = (big.sign == sml.sign) ? (sig_b + sig_s) : (sig_b - sig_s);

        lead = '0;
        for (int i = 0; i < 50; i++) begin
            if (r[i]) lead = 6'(i);
        end
        nrm   = 24'((r << (6'd49 - lead)) >> 26);
        exp_r = $signed({2'b00, big.exp}) + $signed({4'b0000, lead}) - 10'sd48;

        sum = '0;
        ovf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
            sum = FP_NAN;
            ovf = 1'b1;
        end else if (a_inf) begin
            sum = a;
            ovf = 1'b1;
        end else if (b_inf) begin
            sum = b;
            ovf = 1'b1;
        end else if (a_zero && b_zero) begin
            sum = {fa.sign & fb.sign, 31'b0};
        end else if (a_zero) begin
            sum = b;
        end else if (b_zero) begin
            sum = a;
        end else if (diff >= 8'd25) begin
            sum = big;
        end else if (!nrm[23]) begin
            sum = '0;
        end else if (exp_r >= 10'sd255) begin
            sum = {big.sign, FP_EXP_INF, 23'b0};
            ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            sum = {big.sign, 31'b0};
        end else begin
            sum = {big.sign, exp_r[7:0], nrm[22:0]};
        end
    end
endmodule

// File: rtl/fp_dot_accumulator.sv
// Sums K fp32 products per dot product, one term per cycle, with a sticky
// overflow/NaN flag; completed sums are registered with a one-cycle valid pulse.
module fp_dot_accumulator
    import fp32_pkg::*;
#(
    parameter int K     = 4,
    parameter int CNT_W = $clog2(K) + 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_prod,
    input  logic        i_prod_vld,
    input  logic        i_prod_ovf,
    input  logic        i_clr,
    output logic [31:0] o_sum,
    output logic        o_sum_vld,
    output logic        o_overflow
);
    acc_state_e        state_q, state_d;
    logic [31:0]       acc_q, acc_d, sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, term_cnt;
    logic              sticky_q, sticky_d, ovf_q, ovf_d, vld_q, vld_d;
    logic              take_first, last;
    logic [31:0]       add_sum, term_val;
    logic              add_ovf, term_flag;

    fp_adder_32bit u_add (
        .a   (acc_q),
        .b   (i_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // A clear alongside a valid term restarts the dot product with that term.
    assign take_first = (state_q == ST_IDLE) || i_clr;
    assign term_cnt   = take_first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign last       = i_prod_vld && (term_cnt == CNT_W'(K));
    assign term_val   = take_first ? i_prod : add_sum;
    assign term_flag  = take_first ? i_prod_ovf : (sticky_q | i_prod_ovf | add_ovf);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_prod_vld)  state_d = last ? ST_IDLE : ST_ACCUM;
        else if (i_clr)  state_d = ST_IDLE;
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        vld_d    = 1'b0;
        if (i_prod_vld) begin
            if (last) begin
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
                sum_d    = term_val;
                ovf_d    = term_flag;
                vld_d    = 1'b1;
            end else begin
                acc_d    = term_val;
                cnt_d    = term_cnt;
                sticky_d = term_flag;
            end
        end else if (i_clr) begin
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            vld_q    <= vld_d;
        end
    end

    assign o_sum      = sum_q;
    assign o_sum_vld  = vld_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_fp_dot_accumulator.sv
// Scoreboard bench for fp_dot_accumulator (K=4): directed dot products with
// hand-computed sums; a negedge monitor pops expectations on every o_sum_vld.
module tb_fp_dot_accumulator;
    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, vld, pov, clr;
    logic [31:0] prod;
    logic [31:0] o_sum;
    logic        o_sum_vld, o_overflow;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fp_dot_accumulator #(.K(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_prod     (prod),
        .i_prod_vld (vld),
        .i_prod_ovf (pov),
        .i_clr      (clr),
        .o_sum      (o_sum),
        .o_sum_vld  (o_sum_vld),
        .o_overflow (o_overflow)
    );

    always @(negedge clk) begin
        exp_t e;
        if (o_sum_vld === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got o_sum=%h ovf=%b, no result expected", o_sum, o_overflow);
            end else begin
                e = sb.pop_front();
                if (o_sum !== e.sum || o_overflow !== e.ovf) begin
                    fails++;
                    $display("FAIL result: got o_sum=%h ovf=%b, want %h ovf=%b", o_sum, o_overflow, e.sum, e.ovf);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic term(input logic [31:0] p, input logic f = 1'b0, input logic c = 1'b0);
        prod = p;
        vld  = 1'b1;
        pov  = f;
        clr  = c;
        @(posedge clk);
        #1;
        vld  = 1'b0;
        pov  = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_sum(input logic [31:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic dot4(input logic [31:0] t0, t1, t2, t3, input logic [31:0] s, input logic o);
        expect_sum(s, o);
        term(t0);
        term(t1);
        term(t2);
        term(t3);
    endtask

    // Wait (bounded) for outstanding results, then check the pulse dropped and outputs hold.
    task automatic settle(input string name, input logic [31:0] s, input logic o);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending results, want 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk({name, "_vld_low"}, {31'b0, o_sum_vld}, 32'd0);
        chk({name, "_sum_hold"}, o_sum, s);
        chk({name, "_ovf_hold"}, {31'b0, o_overflow}, {31'b0, o});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        pov  = 1'b0;
        clr  = 1'b0;
        prod = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_sum", o_sum, 32'h0);
        chk("reset_vld", {31'b0, o_sum_vld}, 32'd0);
        chk("reset_ovf", {31'b0, o_overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        dot4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 1'b0);
        settle("sum_1234", 32'h41200000, 1'b0);

        // Back-to-back dot products: cancellation then exponent overflow.
        dot4(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'hBF000000, 32'h00000000, 1'b0);
        dot4(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1);
        settle("b2b_overflow", 32'h7F800000, 1'b1);

        dot4(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1);
        settle("inf_minus_inf", 32'h7FC00000, 1'b1);

        dot4(32'h3F800000, 32'hB3C00000, 32'h00000000, 32'h00000000, 32'h3F7FFFFE, 1'b0);
        settle("trunc_sub", 32'h3F7FFFFE, 1'b0);

        dot4(32'h4B800000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h4B800000, 1'b0);
        settle("shift24_trunc", 32'h4B800000, 1'b0);

        dot4(32'h4C000000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h4C000000, 1'b0);
        settle("shift25_big", 32'h4C000000, 1'b0);

        dot4(32'h00400000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000, 1'b0);
        settle("subnormal_flush", 32'h3F800000, 1'b0);

        dot4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
        settle("neg_zero", 32'h80000000, 1'b0);

        expect_sum(32'h40800000, 1'b1);
        term(32'h3F800000);
        term(32'h3F800000, 1'b1);
        term(32'h3F800000);
        term(32'h3F800000);
        settle("upstream_ovf", 32'h40800000, 1'b1);

        dot4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 1'b0);
        settle("sticky_cleared", 32'h40800000, 1'b0);

        expect_sum(32'h40800000, 1'b0);
        term(32'h3F800000);
        term(32'h3F800000);
        term(32'h3F800000, 1'b0, 1'b1);
        term(32'h3F800000);
        term(32'h3F800000);
        term(32'h3F800000);
        settle("clr_restart", 32'h40800000, 1'b0);

        // Partial sum behind gaps, then reset: no pulse and outputs cleared.
        dot4(32'h3F800000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h40400000, 1'b1 ^ 1'b1);
        settle("pre_reset", 32'h40400000, 1'b0);
        term(32'h3F800000);
        idle(3);
        term(32'h3F800000);
        idle(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_sum", o_sum, 32'h0);
        chk("midrst_vld", {31'b0, o_sum_vld}, 32'd0);
        @(posedge clk);
        #1;
        expect_sum(32'h40800000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            term(32'h3F800000);
            idle(3);
        end
        settle("after_reset", 32'h40800000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
